// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction-fetch front end. Owns the PC, issues reads to a
//                synchronous instruction memory (1-cycle latency), buffers
//                returned instructions in a small FIFO and hands them to
//                decode over a valid/ready handshake. Redirects flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
   parameter int              PC_W     = 8,
   parameter int              INSTR_W  = 19,
   parameter int              DEPTH    = 2,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     imem_rd_en,
   output logic [PC_W-1:0]          imem_addr,
   input  logic [INSTR_W-1:0]       imem_rdata,
   input  logic                     redirect_valid,
   input  logic [PC_W-1:0]          redirect_pc,
   input  logic                     fetch_halt,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [INSTR_W-1:0]       out_instr,
   output logic [PC_W-1:0]          out_pc,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int c_aw = $clog2(DEPTH);
   localparam int c_cw = c_aw + 1;

   localparam logic [c_cw:0]   c_depth   = (c_cw + 1)'(DEPTH);
   localparam logic [c_cw-1:0] c_one_cnt = c_cw'(1);
   localparam logic [c_aw-1:0] c_one_ptr = c_aw'(1);
   localparam logic [PC_W-1:0] c_one_pc  = PC_W'(1);

   // Architectural / pipeline state
   logic [PC_W-1:0]    r_pc;
   logic [PC_W-1:0]    r_tag_pc;      // pc of the read whose data lands this cycle
   logic               r_inflight;    // a read was issued on the previous edge
   logic [c_aw-1:0]    r_wr_ptr;
   logic [c_aw-1:0]    r_rd_ptr;
   logic [c_cw-1:0]    r_count;

   // FIFO storage (data only, no reset needed)
   logic [INSTR_W-1:0] r_instr_mem [DEPTH];
   logic [PC_W-1:0]    r_pc_mem    [DEPTH];

   logic               w_nonempty;
   logic               w_out_valid;
   logic               w_pop;
   logic               w_push;
   logic               w_issue;
   logic [c_cw:0]      w_used;
   logic [c_cw-1:0]    w_count_nxt;

   // Handshake, push and credit decisions
   always_comb begin
      w_nonempty  = (r_count != '0);
      // A redirect hides the head entry so nothing transfers that cycle.
      w_out_valid = reset & ~redirect_valid & w_nonempty;
      w_pop       = w_out_valid & out_ready;
      // The only read that can be stale is the one landing during the redirect
      // cycle itself: a redirect cycle never issues, so gating the push here
      // is all the kill logic that is required.
      w_push      = reset & r_inflight & ~redirect_valid;
      // Credit: occupied slots after this cycle's pop, counting the read that
      // is about to land. A same-cycle pop frees its slot immediately so that
      // steady streaming sustains one instruction per cycle.
      w_used      = {1'b0, r_count}
                    + {{c_cw{1'b0}}, r_inflight}
                    - {{c_cw{1'b0}}, w_pop};
      w_issue     = reset & ~redirect_valid & ~fetch_halt & (w_used < c_depth);
   end

   // Next occupancy from push/pop
   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + c_one_cnt;
         2'b01:   w_count_nxt = r_count - c_one_cnt;
         default: w_count_nxt = r_count;
      endcase
   end

   // PC, inflight tag and FIFO pointer registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc       <= RESET_PC;
         r_tag_pc   <= '0;
         r_inflight <= 1'b0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_tag_pc <= r_pc;
         end
         if (redirect_valid) begin
            r_pc     <= redirect_pc;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_issue) begin
               r_pc <= r_pc + c_one_pc;
            end
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + c_one_ptr;
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + c_one_ptr;
            end
            r_count <= w_count_nxt;
         end
      end
   end

   // Capture returning instruction together with its pc
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_instr_mem[r_wr_ptr] <= imem_rdata;
         r_pc_mem[r_wr_ptr]    <= r_tag_pc;
      end
   end

   // Output drive; empty FIFO presents zeros
   always_comb begin
      imem_rd_en = w_issue;
      imem_addr  = r_pc;
      out_valid  = w_out_valid;
      out_instr  = w_nonempty ? r_instr_mem[r_rd_ptr] : '0;
      out_pc     = w_nonempty ? r_pc_mem[r_rd_ptr]    : '0;
      fifo_count = r_count;
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage: queue-based reference
//                model compared every cycle, directed scenarios with literal
//                expectations, then a randomized phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

   localparam int PC_W    = 8;
   localparam int INSTR_W = 19;
   localparam int DEPTH   = 2;

   logic               clk;
   logic               reset;
   logic               imem_rd_en;
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic               redirect_valid;
   logic [PC_W-1:0]    redirect_pc;
   logic               fetch_halt;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [PC_W-1:0]    out_pc;
   logic [1:0]         fifo_count;

   int checks = 0;
   int errors = 0;

   logic [INSTR_W-1:0] mem [256];

   fetch_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_rd_en     (imem_rd_en),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_halt     (fetch_halt),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .fifo_count     (fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous instruction memory, 1-cycle read latency
   initial imem_rdata = '0;
   always @(posedge clk) begin
      if (imem_rd_en) imem_rdata <= mem[imem_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [PC_W-1:0] m_pc;
   logic [PC_W-1:0] m_q[$];      // pcs of buffered instructions, oldest first
   bit              m_inf;       // a read lands in the current cycle
   logic [PC_W-1:0] m_tag;

   initial begin
      m_pc = '0; m_inf = 0; m_tag = '0;
   end

   always @(negedge clk) begin
      bit              e_valid, e_pop, e_rd;
      int              used;
      if (!reset) begin
         check("rst_valid", 32'(out_valid), 32'd0);
         check("rst_count", 32'(fifo_count), 32'd0);
         check("rst_rden",  32'(imem_rd_en), 32'd0);
         check("rst_instr", 32'(out_instr), 32'd0);
         check("rst_pc",    32'(out_pc), 32'd0);
         m_pc = '0; m_q.delete(); m_inf = 0; m_tag = '0;
      end else begin
         e_valid = !redirect_valid && (m_q.size() > 0);
         e_pop   = e_valid && out_ready;
         used    = m_q.size() + int'(m_inf) - int'(e_pop);
         e_rd    = !redirect_valid && !fetch_halt && (used < DEPTH);
         check("m_valid", 32'(out_valid), 32'(e_valid));
         check("m_count", 32'(fifo_count), 32'(m_q.size()));
         check("m_rden",  32'(imem_rd_en), 32'(e_rd));
         if (e_valid) begin
            check("m_outpc", 32'(out_pc), 32'(m_q[0]));
            check("m_instr", 32'(out_instr), 32'(mem[m_q[0]]));
         end
         if (e_rd) check("m_addr", 32'(imem_addr), 32'(m_pc));
         // advance to the next cycle
         if (redirect_valid) begin
            m_q.delete();
            m_inf = 0;
            m_pc  = redirect_pc;
         end else begin
            if (e_pop) void'(m_q.pop_front());
            if (m_inf) m_q.push_back(m_tag);
            m_inf = e_rd;
            if (e_rd) begin
               m_tag = m_pc;
               m_pc  = m_pc + 8'd1;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [PC_W-1:0] held_pc;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = INSTR_W'(i + 'h100);
      reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      fetch_halt = 1'b0; out_ready = 1'b1;
      repeat (3) step();

      // 1: reset release and streaming
      step(); reset = 1'b1;
      #2 check("t1_rd0", 32'(imem_rd_en), 32'd1);
      check("t1_addr0", 32'(imem_addr), 32'h0);
      check("t1_v0", 32'(out_valid), 32'd0);
      step(); #2 check("t1_addr1", 32'(imem_addr), 32'h1);
      check("t1_v1", 32'(out_valid), 32'd0);
      step(); #2 check("t1_v2", 32'(out_valid), 32'd1);
      check("t1_pc0", 32'(out_pc), 32'h0);
      check("t1_in0", 32'(out_instr), 32'h100);
      check("t1_addr2", 32'(imem_addr), 32'h2);
      step(); #2 check("t1_pc1", 32'(out_pc), 32'h1);
      check("t1_in1", 32'(out_instr), 32'h101);
      step(); #2 check("t1_pc2", 32'(out_pc), 32'h2);
      check("t1_in2", 32'(out_instr), 32'h102);

      // 2: stall for 5 cycles
      step(); out_ready = 1'b0;
      #2 held_pc = out_pc;
      check("t2_first", 32'(held_pc), 32'h3);
      repeat (5) step();
      #2 check("t2_count", 32'(fifo_count), 32'd2);
      check("t2_rden", 32'(imem_rd_en), 32'd0);
      check("t2_hold", 32'(out_pc), 32'h3);
      check("t2_hinstr", 32'(out_instr), 32'h103);

      // 3: redirect to 0x40 while full
      step(); redirect_valid = 1'b1; redirect_pc = 8'h40; out_ready = 1'b1;
      #2 check("t3_v", 32'(out_valid), 32'd0);
      check("t3_rd", 32'(imem_rd_en), 32'd0);
      step(); redirect_valid = 1'b0;
      #2 check("t3_cnt", 32'(fifo_count), 32'd0);
      check("t3_v1", 32'(out_valid), 32'd0);
      check("t3_addr", 32'(imem_addr), 32'h40);
      check("t3_rd1", 32'(imem_rd_en), 32'd1);
      step(); step();
      #2 check("t3_pc", 32'(out_pc), 32'h40);
      check("t3_vld", 32'(out_valid), 32'd1);

      // 4: back-to-back redirects
      step(); redirect_valid = 1'b1; redirect_pc = 8'h10;
      step(); redirect_pc = 8'h20;
      step(); redirect_valid = 1'b0;
      #2 check("t4_addr", 32'(imem_addr), 32'h20);
      step(); step();
      #2 check("t4_pc", 32'(out_pc), 32'h20);
      check("t4_in", 32'(out_instr), 32'h120);

      // 5: pc wrap, then halt drain and resume
      step(); redirect_valid = 1'b1; redirect_pc = 8'hFE;
      step(); redirect_valid = 1'b0;
      step();
      step(); #2 check("t5_wrapaddr", 32'(imem_addr), 32'h00);
      check("t5_pcFE", 32'(out_pc), 32'hFE);
      step(); #2 check("t5_pcFF", 32'(out_pc), 32'hFF);
      step(); #2 check("t5_pc00", 32'(out_pc), 32'h00);
      check("t5_addr2", 32'(imem_addr), 32'h02);
      step(); fetch_halt = 1'b1;
      repeat (4) step();
      #2 check("t5_hv", 32'(out_valid), 32'd0);
      check("t5_hrd", 32'(imem_rd_en), 32'd0);
      check("t5_hcnt", 32'(fifo_count), 32'd0);
      step(); fetch_halt = 1'b0;
      #2 check("t5_resume", 32'(imem_addr), 32'h03);
      check("t5_rrd", 32'(imem_rd_en), 32'd1);

      // 6: asynchronous reset mid-stream
      step(); out_ready = 1'b0;
      step(); step();
      #2 check("t6_pre", 32'(fifo_count != 0), 32'd1);
      @(posedge clk); #2 reset = 1'b0;
      #1 check("t6_v", 32'(out_valid), 32'd0);
      check("t6_cnt", 32'(fifo_count), 32'd0);
      repeat (2) step();
      reset = 1'b1; out_ready = 1'b1;
      #2 check("t6_addr", 32'(imem_addr), 32'h00);
      check("t6_rd", 32'(imem_rd_en), 32'd1);

      // randomized phase
      for (int i = 0; i < 256; i++) mem[i] = INSTR_W'($urandom);
      repeat (3000) begin
         step();
         out_ready      = ($urandom_range(0, 3) != 0);
         fetch_halt     = ($urandom_range(0, 9) == 0);
         redirect_valid = ($urandom_range(0, 11) == 0);
         redirect_pc    = PC_W'($urandom);
         reset          = ($urandom_range(0, 499) != 0);
      end
      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
